// File: rtl/uart_rx_cfg_if.sv
// Receive-side handshake bundle for uart_rx_cfg.
//   rx_data  : received word, LSB-aligned, unused upper bits zero
//   rx_valid : held word available
//   rx_err   : {parity, overrun, frame} flags for the held word
//   rx_ready : consumer accepts the held word while rx_valid is high
// master = receiver (drives the word), slave = consumer (drives rx_ready).
interface uart_rx_cfg_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_err;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, output rx_err, input rx_ready);
    modport slave  (input rx_data, input rx_valid, input rx_err, output rx_ready);
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable oversampling UART receiver (5-8 data bits, none/even/odd
// parity, one or two stop bits) with a single-word holding register.
//   clk, rst      : clock, asynchronous active-high reset
//   os_tick_i     : single-clk strobe at OVS x baud
//   din_i         : asynchronous serial line, idles high
//   data_bits_i   : 00=5 .. 11=8 data bits
//   par_mode_i    : 00 none, 01 even, 10 odd, 11 none
//   stop2_i       : check a second stop bit
//   busy_o        : receiver is not idle
//   rx_bus        : word/flags/valid out, ready in
module uart_rx_cfg #(
    parameter int unsigned OVS         = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          os_tick_i,
    input  logic          din_i,
    input  logic [1:0]    data_bits_i,
    input  logic [1:0]    par_mode_i,
    input  logic          stop2_i,
    output logic          busy_o,
    uart_rx_cfg_if.master rx_bus
);
    localparam int unsigned      CNT_W    = $clog2(OVS);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic [1:0]             db_q, db_d;
    logic [1:0]             pm_q, pm_d;
    logic                   s2_q, s2_d;
    logic                   par_err_q, par_err_d;
    logic                   frm_err_q, frm_err_d;
    logic                   armed_q, armed_d;
    logic                   done_q, done_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic [2:0]             rx_err_q, rx_err_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   busy_q;
    logic                   full_hit, half_hit, last_bit, par_en, par_odd;

    assign line     = sync_q[SYNC_STAGES-1];
    assign full_hit = (cnt_q == CNT_FULL);
    assign half_hit = (cnt_q == CNT_HALF);
    assign last_bit = (bit_q == (3'(db_q) + 3'd4));
    assign par_en   = pm_q[0] ^ pm_q[1];
    assign par_odd  = (pm_q == 2'b10);

    assign busy_o          = busy_q;
    assign rx_bus.rx_data  = rx_data_q;
    assign rx_bus.rx_err   = rx_err_q;
    assign rx_bus.rx_valid = rx_valid_q;

    // Line synchroniser; resets to the idle (high) level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '1;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic, advanced only on oversampling ticks
    always_comb begin
        state_d = state_q;
        if (os_tick_i) begin
            case (state_q)
                S_IDLE:   if (armed_q && !line) state_d = S_START;
                S_START:  if (half_hit) state_d = line ? S_IDLE : S_DATA;
                S_DATA:   if (full_hit && last_bit) state_d = par_en ? S_PARITY : S_STOP1;
                S_PARITY: if (full_hit) state_d = S_STOP1;
                S_STOP1:  if (full_hit) state_d = (s2_q && line) ? S_STOP2 : S_IDLE;
                S_STOP2:  if (full_hit) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        db_d       = db_q;
        pm_d       = pm_q;
        s2_d       = s2_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        armed_d    = armed_q;
        done_d     = 1'b0;
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;
        rx_valid_d = rx_valid_q;

        if (os_tick_i) begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A held-low line after a frame error must go high before re-arming
                    if (line) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        db_d      = data_bits_i;
                        pm_d      = par_mode_i;
                        s2_d      = stop2_i;
                        shift_d   = '0;
                        par_err_d = 1'b0;
                        frm_err_d = 1'b0;
                    end
                end
                S_START: cnt_d = half_hit ? '0 : cnt_q + CNT_W'(1);
                S_DATA: begin
                    cnt_d = full_hit ? '0 : cnt_q + CNT_W'(1);
                    if (full_hit) begin
                        shift_d[bit_q] = line;
                        bit_d          = bit_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    cnt_d = full_hit ? '0 : cnt_q + CNT_W'(1);
                    if (full_hit) par_err_d = (^shift_q) ^ line ^ par_odd;
                end
                S_STOP1: begin
                    cnt_d = full_hit ? '0 : cnt_q + CNT_W'(1);
                    if (full_hit) begin
                        if (!line) begin
                            frm_err_d = 1'b1;
                            armed_d   = 1'b0;
                        end
                        if (!(s2_q && line)) done_d = 1'b1;
                    end
                end
                S_STOP2: begin
                    cnt_d = full_hit ? '0 : cnt_q + CNT_W'(1);
                    if (full_hit) begin
                        if (!line) begin
                            frm_err_d = 1'b1;
                            armed_d   = 1'b0;
                        end
                        done_d = 1'b1;
                    end
                end
                default: cnt_d = '0;
            endcase
        end

        // Completion wins over acceptance; overrun only when the old word was not taken
        if (done_q) begin
            rx_data_d  = shift_q;
            rx_err_d   = {par_err_q, rx_valid_q && !rx_bus.rx_ready, frm_err_q};
            rx_valid_d = 1'b1;
        end else if (rx_valid_q && rx_bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            db_q       <= '0;
            pm_q       <= '0;
            s2_q       <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            armed_q    <= 1'b1;
            done_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_err_q   <= '0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            db_q       <= db_d;
            pm_q       <= pm_d;
            s2_q       <= s2_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            armed_q    <= armed_d;
            done_q     <= done_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= (state_d != S_IDLE);
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_uart_rx_cfg;
    localparam int unsigned OVS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os_tick = 1'b0;
    logic       din = 1'b1;
    logic [1:0] data_bits = 2'b11;
    logic [1:0] par_mode = 2'b00;
    logic       stop2 = 1'b0;
    logic       busy;
    int         passed = 0;
    int         total = 0;
    int         tdiv = 0;

    uart_rx_cfg_if bus();

    uart_rx_cfg #(.OVS(OVS), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .os_tick_i  (os_tick),
        .din_i      (din),
        .data_bits_i(data_bits),
        .par_mode_i (par_mode),
        .stop2_i    (stop2),
        .busy_o     (busy),
        .rx_bus     (bus)
    );

    always #5 clk = ~clk;

    // Oversampling strobe: one clk in three
    initial begin
        forever begin
            @(negedge clk);
            tdiv    = (tdiv == 2) ? 0 : tdiv + 1;
            os_tick = (tdiv == 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (os_tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        din = b;
        wait_ticks(OVS);
    endtask

    // Serialise one frame; optionally disturb config after the start bit
    task automatic send_frame(input logic [7:0] d, input logic [1:0] db, input logic [1:0] pm,
                              input logic s2, input bit bad_par, input bit s1v, input bit s2v,
                              input bit scramble, input bit low_after);
        int         n;
        logic [7:0] m;
        logic       p;
        n = int'(db) + 5;
        m = d & 8'((1 << n) - 1);
        @(negedge clk);
        data_bits = db;
        par_mode  = pm;
        stop2     = s2;
        send_bit(1'b0);
        if (scramble) begin
            @(negedge clk);
            data_bits = 2'($urandom);
            par_mode  = 2'($urandom);
            stop2     = 1'($urandom);
        end
        for (int i = 0; i < n; i++) send_bit(m[i]);
        if (pm == 2'b01 || pm == 2'b10) begin
            p = (^m) ^ (pm == 2'b10) ^ bad_par;
            send_bit(p);
        end
        send_bit(s1v);
        if (s2) send_bit(s2v);
        @(negedge clk);
        din = low_after ? 1'b0 : 1'b1;
        wait_ticks(2 * OVS);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.rx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic accept();
        @(negedge clk);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.rx_ready = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (bus.rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", bus.rx_data); else passed++;
        total++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.rx_valid); else passed++;
        total++; if (bus.rx_err !== 3'b000) $display("FAIL reset_err: got %b want 000", bus.rx_err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        rst = 1'b0;
        wait_ticks(OVS);
    endtask

    task automatic test_8n1();
        bit ok;
        send_frame(8'hA5, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_valid(ok);
        total++; if (!ok) $display("FAIL a5_valid: got 0 want 1"); else passed++;
        total++; if (bus.rx_data !== 8'hA5) $display("FAIL a5_data: got %h want a5", bus.rx_data); else passed++;
        total++; if (bus.rx_err !== 3'b000) $display("FAIL a5_err: got %b want 000", bus.rx_err); else passed++;
        repeat (40) @(negedge clk);
        total++; if (bus.rx_valid !== 1'b1) $display("FAIL a5_hold: got %b want 1", bus.rx_valid); else passed++;
        accept();
        total++; if (bus.rx_valid !== 1'b0) $display("FAIL a5_accept: got %b want 0", bus.rx_valid); else passed++;
    endtask

    task automatic test_parity();
        bit ok;
        send_frame(8'h13, 2'b00, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_valid(ok);
        total++; if (!ok) $display("FAIL par_valid: got 0 want 1"); else passed++;
        total++; if (bus.rx_data !== 8'h13) $display("FAIL par_data: got %h want 13", bus.rx_data); else passed++;
        total++; if (bus.rx_err !== 3'b100) $display("FAIL par_err: got %b want 100", bus.rx_err); else passed++;
        accept();
    endtask

    task automatic test_stop2_break();
        bit ok;
        send_frame(8'h5A, 2'b11, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_valid(ok);
        total++; if (!ok) $display("FAIL brk_valid: got 0 want 1"); else passed++;
        total++; if (bus.rx_data !== 8'h5A) $display("FAIL brk_data: got %h want 5a", bus.rx_data); else passed++;
        total++; if (bus.rx_err !== 3'b001) $display("FAIL brk_err: got %b want 001", bus.rx_err); else passed++;
        accept();
        wait_ticks(3 * OVS);
        total++; if (busy !== 1'b0) $display("FAIL brk_busy: got %b want 0", busy); else passed++;
        total++; if (bus.rx_valid !== 1'b0) $display("FAIL brk_novalid: got %b want 0", bus.rx_valid); else passed++;
        @(negedge clk);
        din = 1'b1;
        wait_ticks(OVS);
        send_frame(8'h81, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_valid(ok);
        total++; if (!ok || bus.rx_data !== 8'h81) $display("FAIL brk_rearm: got %h want 81", bus.rx_data); else passed++;
        accept();
    endtask

    task automatic test_overrun();
        bit ok;
        send_frame(8'h11, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_valid(ok);
        total++; if (!ok) $display("FAIL ovr_valid: got 0 want 1"); else passed++;
        total++; if (bus.rx_data !== 8'h22) $display("FAIL ovr_data: got %h want 22", bus.rx_data); else passed++;
        total++; if (bus.rx_err !== 3'b010) $display("FAIL ovr_err: got %b want 010", bus.rx_err); else passed++;
        accept();
    endtask

    task automatic test_false_start();
        @(negedge clk);
        din = 1'b0;
        wait_ticks(6);
        @(negedge clk);
        din = 1'b1;
        wait_ticks(1);
        total++; if (busy !== 1'b1) $display("FAIL fs_busy_mid: got %b want 1", busy); else passed++;
        wait_ticks(12);
        total++; if (busy !== 1'b0) $display("FAIL fs_busy_end: got %b want 0", busy); else passed++;
        total++; if (bus.rx_valid !== 1'b0) $display("FAIL fs_valid: got %b want 0", bus.rx_valid); else passed++;
    endtask

    // Randomized frames against the frame-level model
    task automatic test_random();
        bit         ok, bad, s1v, s2v, pen, exp_frm;
        logic [7:0] d, m;
        logic [1:0] db, pm;
        logic       s2;
        for (int k = 0; k < 16; k++) begin
            d   = 8'($urandom);
            db  = 2'($urandom);
            pm  = 2'($urandom);
            s2  = 1'($urandom);
            pen = (pm == 2'b01) || (pm == 2'b10);
            bad = pen && ($urandom_range(3) == 0);
            s1v = ($urandom_range(7) != 0);
            s2v = ($urandom_range(7) != 0);
            send_frame(d, db, pm, s2, bad, s1v, s2v, 1'($urandom), 1'b0);
            m       = d & 8'((1 << (int'(db) + 5)) - 1);
            exp_frm = !s1v || (s2 && !s2v);
            wait_valid(ok);
            total++; if (!ok) $display("FAIL rnd%0d_valid: got 0 want 1", k); else passed++;
            total++; if (bus.rx_data !== m) $display("FAIL rnd%0d_data: got %h want %h", k, bus.rx_data, m); else passed++;
            total++; if (bus.rx_err !== {bad, 1'b0, exp_frm})
                $display("FAIL rnd%0d_err: got %b want %b", k, bus.rx_err, {bad, 1'b0, exp_frm}); else passed++;
            accept();
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        @(negedge clk);
        data_bits = 2'b11;
        par_mode  = 2'b00;
        stop2     = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        wait_ticks(OVS / 2);
        total++; if (busy !== 1'b1) $display("FAIL rm_busy_pre: got %b want 1", busy); else passed++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) $display("FAIL rm_busy: got %b want 0", busy); else passed++;
        total++; if (bus.rx_data !== 8'h00) $display("FAIL rm_data: got %h want 00", bus.rx_data); else passed++;
        total++; if (bus.rx_err !== 3'b000) $display("FAIL rm_err: got %b want 000", bus.rx_err); else passed++;
        total++; if (bus.rx_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", bus.rx_valid); else passed++;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(4 * OVS);
        total++; if (bus.rx_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL rm_discard: got valid=%b busy=%b want 0 0", bus.rx_valid, busy); else passed++;
        send_frame(8'h3C, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_valid(ok);
        total++; if (!ok) $display("FAIL rm_next_valid: got 0 want 1"); else passed++;
        total++; if (bus.rx_data !== 8'h3C) $display("FAIL rm_next_data: got %h want 3c", bus.rx_data); else passed++;
        total++; if (bus.rx_err !== 3'b000) $display("FAIL rm_next_err: got %b want 000", bus.rx_err); else passed++;
        accept();
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_stop2_break();
        test_overrun();
        test_false_start();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
